topk_merge_sched: RTL and testbench

Sequencer for a streaming partial sort: accepts K-element chunks of signed 16-bit samples, feeds each chunk and the running top-K list into the external max-K + bitonic merge unit, and writes the merged result back as the new running list. At frame end it presents the frame's top-K (descending) on a valid/ready output. It sits between the upstream chunk sorter and the merge datapath; the merge unit stays outside this block.

---
 rtl/topk_pkg.sv | 30 +++
 rtl/topk_merge_sched.sv | 115 +++++++++++
 tb/tb_topk_merge_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/topk_pkg.sv
// Shared types and constants for the streaming top-K merge sequencer.
// Lane i of a K*W bus occupies bits [i*W +: W]; lane 0 is the first list element.
package topk_pkg;

  localparam int unsigned KDef = 8;
  localparam int unsigned WDef = 16;

  localparam logic [WDef-1:0] MinVal = {1'b1, {(WDef-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StEmit = 2'd2
  } state_e;

  function automatic logic [WDef-1:0] get_lane(input logic [KDef*WDef-1:0] bus,
                                               input int unsigned idx);
    return bus[idx*WDef +: WDef];
  endfunction

  function automatic logic [KDef*WDef-1:0] put_lane(input logic [KDef*WDef-1:0] bus,
                                                    input int unsigned idx,
                                                    input logic [WDef-1:0] val);
    logic [KDef*WDef-1:0] res;
    res = bus;
    res[idx*WDef +: WDef] = val;
    return res;
  endfunction

endpackage

// File: rtl/topk_merge_sched.sv
// Sequences one chunk at a time through an external max-K/bitonic merge unit and
// keeps the running top-K list; presents the frame result on a valid/ready port.
module topk_merge_sched
  import topk_pkg::*;
#(
  parameter int unsigned K         = KDef,
  parameter int unsigned W         = WDef,
  parameter int unsigned MERGE_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K*W-1:0] in_data,
  input  logic           in_last,
  output logic [K*W-1:0] m_asc,
  output logic [K*W-1:0] m_desc,
  input  logic [K*W-1:0] m_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K*W-1:0] out_data,
  output logic [15:0]    out_count,
  output logic           busy
);

  localparam int unsigned   CntW    = $clog2(MERGE_LAT + 1);
  localparam logic [W-1:0]   LaneMin = {1'b1, {(W-1){1'b0}}};
  localparam logic [K*W-1:0] ListMin = {K{LaneMin}};

  state_e           state_q, state_d;
  logic [K*W-1:0]   chunk_q, chunk_d;
  logic [K*W-1:0]   run_q, run_d;
  logic [K*W-1:0]   res_q, res_d;
  logic [CntW-1:0]  wait_q, wait_d;
  logic             last_q, last_d;
  logic [15:0]      cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    chunk_d   = chunk_q;
    run_d     = run_q;
    res_d     = res_q;
    wait_d    = wait_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          chunk_d = in_data;
          last_d  = in_last;
          wait_d  = CntW'(MERGE_LAT);
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          state_d = StWait;
        end
      end
      StWait: begin
        // Inputs to the merge unit stay frozen; sample its output once it has settled.
        if (wait_q == '0) begin
          run_d = m_out;
          if (last_q) begin
            res_d   = m_out;
            state_d = StEmit;
          end else begin
            state_d = StIdle;
          end
        end else begin
          wait_d = wait_q - CntW'(1);
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        if (out_ready) begin
          run_d   = ListMin;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      chunk_q <= '0;
      run_q   <= ListMin;
      res_q   <= '0;
      wait_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      run_q   <= run_d;
      res_q   <= res_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_asc     = chunk_q;
  assign m_desc    = run_q;
  assign out_data  = res_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_topk_merge_sched.sv
// Directed bench for topk_merge_sched with a behavioural pipelined merge unit.
module tb_topk_merge_sched;
  import topk_pkg::*;

  localparam int unsigned K  = 8;
  localparam int unsigned W  = 16;
  localparam int unsigned ML = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [K*W-1:0] in_data;
  logic           in_last;
  logic [K*W-1:0] m_asc;
  logic [K*W-1:0] m_desc;
  logic [K*W-1:0] m_out;
  logic           out_valid;
  logic           out_ready;
  logic [K*W-1:0] out_data;
  logic [15:0]    out_count;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  topk_merge_sched #(.K(K), .W(W), .MERGE_LAT(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .m_asc     (m_asc),
    .m_desc    (m_desc),
    .m_out     (m_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Merge unit: top-K of both lists, descending, through an ML-deep pipeline.
  function automatic logic [K*W-1:0] merge_model(input logic [K*W-1:0] a,
                                                 input logic [K*W-1:0] d);
    logic signed [W-1:0] s [2*K];
    logic signed [W-1:0] t;
    logic [K*W-1:0] r;
    for (int i = 0; i < K; i++) begin
      s[i]     = get_lane(a, i);
      s[i + K] = get_lane(d, i);
    end
    for (int i = 0; i < 2*K; i++) begin
      for (int j = 0; j < 2*K-1; j++) begin
        if (s[j] < s[j+1]) begin
          t      = s[j];
          s[j]   = s[j+1];
          s[j+1] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < K; i++) r = put_lane(r, i, s[i]);
    return r;
  endfunction

  logic [K*W-1:0] pipe [ML];
  always @(posedge clk) begin
    pipe[0] <= merge_model(m_asc, m_desc);
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end
  assign m_out = pipe[ML-1];

  function automatic logic [K*W-1:0] v8(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [K*W-1:0] obs, input logic [K*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a chunk, then count cycles until in_ready returns or out_valid rises.
  task automatic send(input logic [K*W-1:0] data, input logic last);
    int lat;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '1;
    chk("accept_busy", busy, 1'b1);
    chk("accept_ready_low", in_ready, 1'b0);
    chk("accept_m_asc", m_asc, data);
    lat = 0;
    while (!(in_ready || out_valid) && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, ML + 1);
    chk("end_state_valid", out_valid, last);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", out_valid, 1'b0);
    chk("hs_ready", in_ready, 1'b1);
    chk("hs_run_clear", m_desc, {K{16'h8000}});
    chk("hs_count_clear", out_count, 16'd0);
  endtask

  logic [K*W-1:0] exp_v;
  logic [K*W-1:0] c2;
  logic [K*W-1:0] c3;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_desc", m_desc, {K{16'h8000}});
    chk("rst_m_asc", m_asc, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_count", out_count, 16'd0);
    rst = 1'b1;
    tick();
    chk("idle_ready", in_ready, 1'b1);

    // Single-chunk frame
    send(v8(-5, -1, 0, 2, 3, 7, 9, 100), 1'b1);
    chk("single_data", out_data, v8(100, 9, 7, 3, 2, 0, -1, -5));
    chk("single_count", out_count, 16'd1);
    exp_v = out_data;
    handshake();
    chk("hs_data_hold", out_data, v8(100, 9, 7, 3, 2, 0, -1, -5));

    // Two-chunk frame
    send(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
    chk("two_run", m_desc, v8(8, 7, 6, 5, 4, 3, 2, 1));
    chk("two_mid_count", out_count, 16'd1);
    chk("two_mid_valid", out_valid, 1'b0);
    c2 = v8(5, 6, 7, 8, 20, 30, 40, 50);
    send(c2, 1'b1);
    chk("two_data", out_data, v8(50, 40, 30, 20, 8, 8, 7, 7));
    chk("two_count", out_count, 16'd2);

    // Output stall with a chunk waiting upstream
    c3 = v8(-3, -2, -1, 0, 1, 2, 3, 4);
    in_valid = 1'b1;
    in_data  = c3;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_data", out_data, v8(50, 40, 30, 20, 8, 8, 7, 7));
      chk("stall_count", out_count, 16'd2);
      chk("stall_m_asc", m_asc, c2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_ready", in_ready, 1'b1);
    chk("post_hs_busy", busy, 1'b0);
    chk("post_hs_count", out_count, 16'd0);
    chk("post_hs_run", m_desc, {K{16'h8000}});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("next_accept_busy", busy, 1'b1);
    chk("next_accept_count", out_count, 16'd1);
    chk("next_accept_m_asc", m_asc, c3);
    for (int i = 0; i < ML + 1; i++) begin
      chk("next_wait_valid", out_valid, 1'b0);
      tick();
    end
    chk("next_valid", out_valid, 1'b1);
    chk("next_data", out_data, v8(4, 3, 2, 1, 0, -1, -2, -3));
    handshake();

    // Reset two cycles into a merge
    in_valid = 1'b1;
    in_data  = v8(10, 20, 30, 40, 50, 60, 70, 80);
    in_last  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_run", m_desc, {K{16'h8000}});
    chk("midrst_m_asc", m_asc, '0);
    chk("midrst_count", out_count, 16'd0);
    chk("midrst_out_data", out_data, '0);
    send(v8(-100, -50, -10, -1, 1, 10, 50, 100), 1'b1);
    chk("midrst_frame", out_data, v8(100, 50, 10, 1, -1, -10, -50, -100));
    chk("midrst_frame_count", out_count, 16'd1);
    handshake();

    // Extremes
    send({K{16'h8000}}, 1'b0);
    chk("ext_run_min", m_desc, {K{16'h8000}});
    send({K{16'h7FFF}}, 1'b1);
    chk("ext_data", out_data, {K{16'h7FFF}});
    chk("ext_count", out_count, 16'd2);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
